// File: rtl/pea_pkg.sv
// ============================================================================
//  Module      : pea_pkg
//  Description : Shared encodings, token field layout, degree-table entry type
//                and the log2 helper used across the Polynomial Evaluation
//                Accelerator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pea_pkg;

  // Mode values presented to the enable block
  localparam logic [2:0] MODE_GET = 3'd0;
  localparam logic [2:0] MODE_STP = 3'd1;
  localparam logic [2:0] MODE_EVP = 3'd2;
  localparam logic [2:0] MODE_EVB = 3'd3;
  localparam logic [2:0] MODE_RST = 3'd4;
  localparam logic [2:0] MODE_OUT = 3'd5;

  // Command opcodes
  localparam logic [7:0] OP_STP = 8'h01;
  localparam logic [7:0] OP_EVP = 8'h02;
  localparam logic [7:0] OP_EVB = 8'h03;
  localparam logic [7:0] OP_RST = 8'h04;

  // Status codes
  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_BAD_OP    = 8'h01;
  localparam logic [7:0] ST_UNDEF_VEC = 8'h02;
  localparam logic [7:0] ST_BAD_ARG   = 8'h03;
  localparam logic [7:0] ST_DP_ERR    = 8'h04;
  localparam logic [7:0] ST_TIMEOUT   = 8'h05;

  // Token layout: [15:8] opcode, [7:5] arg1, [4:0] arg2
  localparam int TOKEN_W    = 16;
  localparam int OPCODE_W   = 8;
  localparam int OPCODE_LSB = 8;
  localparam int ARG1_W     = 3;
  localparam int ARG1_LSB   = 5;
  localparam int ARG2_W     = 5;
  localparam int ARG2_LSB   = 0;

  // Degree table geometry
  localparam int DEGREE_W    = 4;
  localparam int NUM_VECTORS = 8;
  localparam int MAX_DEGREE  = 15;

  typedef struct packed {
    logic                valid;
    logic [DEGREE_W-1:0] degree;
  } table_entry_t;

  typedef enum logic [2:0] {
    S_GET     = 3'd0,
    S_LATCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_WAIT_EN = 3'd3,
    S_RUN     = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  // Ceiling log2; log2(1) = 0
  function automatic int pea_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Enable-block mode for a legal opcode
  function automatic logic [2:0] opcode_mode(input logic [7:0] op);
    logic [2:0] m;
    case (op)
      OP_STP:  m = MODE_STP;
      OP_EVP:  m = MODE_EVP;
      OP_EVB:  m = MODE_EVB;
      OP_RST:  m = MODE_RST;
      default: m = MODE_GET;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pea_controller_if.sv
// ============================================================================
//  Module      : pea_controller_if
//  Description : Command FIFO, enable block, datapath and status FIFO signals
//                of the PEA sequencer. master = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pea_controller_if;
  import pea_pkg::*;

  logic [TOKEN_W-1:0]  command_in;
  logic                command_rd_en;
  logic                enable;
  logic [2:0]          mode;
  logic [ARG2_W-1:0]   b;
  logic [DEGREE_W-1:0] N;
  logic [ARG1_W-1:0]   vec_id;
  logic                dp_start;
  logic                dp_done;
  logic                dp_error;
  logic                status_wr_en;
  logic [TOKEN_W-1:0]  status_out;

  modport master (
    input  command_in, enable, dp_done, dp_error,
    output command_rd_en, mode, b, N, vec_id, dp_start, status_wr_en, status_out
  );

  modport slave (
    output command_in, enable, dp_done, dp_error,
    input  command_rd_en, mode, b, N, vec_id, dp_start, status_wr_en, status_out
  );

endinterface

`default_nettype wire

// File: rtl/pea_degree_table.sv
// ============================================================================
//  Module      : pea_degree_table
//  Description : 8 x {valid, degree} register file. Synchronous write and
//                clear-all, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pea_degree_table
  import pea_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [ARG1_W-1:0]   wr_addr,
  input  logic [DEGREE_W-1:0] wr_degree,
  input  logic [ARG1_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DEGREE_W-1:0] rd_degree
);

  table_entry_t entries [NUM_VECTORS];

  // Reset and clear-all invalidate every entry; a write overwrites one entry
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_VECTORS; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_addr] <= {1'b1, wr_degree};
    end
  end

  assign rd_valid  = entries[rd_addr].valid;
  assign rd_degree = entries[rd_addr].degree;

endmodule

`default_nettype wire

// File: rtl/pea_controller.sv
// ============================================================================
//  Module      : pea_controller
//  Description : PEA top-level sequencer. Pops command tokens, validates them
//                against the degree table, drives mode/b/N to the enable
//                block, runs the datapath via dp_start/dp_done and writes one
//                status token per command. All outputs are registered.
//  Options     : PEA_DP_TIMEOUT_EN - adds a watchdog that aborts S_RUN after
//                timeout_cycles cycles with status TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pea_controller
  import pea_pkg::*;
#(
  parameter int buffer_size    = 1024,
  parameter int timeout_cycles = 4096
)
(
  input  logic             clk,
  input  logic             rst,
  pea_controller_if.master bus
);

  localparam int COUNT_W = pea_log2(buffer_size);

  // Degenerate sizes have no meaningful hardware; the block stays empty.
  if (COUNT_W < 1 || timeout_cycles < 1) begin : g_param_guard
  end

  state_t              state, state_next;
  logic [OPCODE_W-1:0] opcode, opcode_next;
  logic [ARG1_W-1:0]   arg1, arg1_next;
  logic [ARG2_W-1:0]   arg2, arg2_next;
  logic [7:0]          code, code_next;

  logic [2:0]          mode_reg, mode_next;
  logic [ARG2_W-1:0]   b_reg, b_next;
  logic [DEGREE_W-1:0] n_reg, n_next;
  logic [ARG1_W-1:0]   vec_reg, vec_next;
  logic                rd_en_reg, rd_en_next;
  logic                start_reg, start_next;
  logic                wr_reg, wr_next;
  logic [TOKEN_W-1:0]  status_reg, status_next;

  logic                tbl_clear, tbl_wr, tbl_rd_valid;
  logic [DEGREE_W-1:0] tbl_rd_degree;

  logic                go_out;
  logic [7:0]          out_code;

`ifdef PEA_DP_TIMEOUT_EN
  localparam int TIMER_W = pea_log2(timeout_cycles) + 1;
  logic [TIMER_W-1:0] timer, timer_next;
`endif

  pea_degree_table u_table (
    .clk       (clk),
    .rst       (rst),
    .clear     (tbl_clear),
    .wr_en     (tbl_wr),
    .wr_addr   (arg1),
    .wr_degree (arg2[DEGREE_W-1:0]),
    .rd_addr   (arg1),
    .rd_valid  (tbl_rd_valid),
    .rd_degree (tbl_rd_degree)
  );

  // State, latched command fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_GET;
      opcode     <= '0;
      arg1       <= '0;
      arg2       <= '0;
      code       <= '0;
      mode_reg   <= MODE_GET;
      b_reg      <= '0;
      n_reg      <= '0;
      vec_reg    <= '0;
      rd_en_reg  <= 1'b0;
      start_reg  <= 1'b0;
      wr_reg     <= 1'b0;
      status_reg <= '0;
    end else begin
      state      <= state_next;
      opcode     <= opcode_next;
      arg1       <= arg1_next;
      arg2       <= arg2_next;
      code       <= code_next;
      mode_reg   <= mode_next;
      b_reg      <= b_next;
      n_reg      <= n_next;
      vec_reg    <= vec_next;
      rd_en_reg  <= rd_en_next;
      start_reg  <= start_next;
      wr_reg     <= wr_next;
      status_reg <= status_next;
    end
  end

`ifdef PEA_DP_TIMEOUT_EN
  // Watchdog counter of cycles spent in S_RUN
  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer_next;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_next  = state;
    opcode_next = opcode;
    arg1_next   = arg1;
    arg2_next   = arg2;
    code_next   = code;
    mode_next   = mode_reg;
    b_next      = b_reg;
    n_next      = n_reg;
    vec_next    = vec_reg;
    rd_en_next  = 1'b0;
    start_next  = 1'b0;
    wr_next     = 1'b0;
    status_next = status_reg;
    tbl_clear   = 1'b0;
    tbl_wr      = 1'b0;
    go_out      = 1'b0;
    out_code    = ST_OK;
`ifdef PEA_DP_TIMEOUT_EN
    timer_next  = timer;
`endif

    case (state)
      S_GET: begin
        if (bus.enable) begin
          rd_en_next = 1'b1;
          state_next = S_LATCH;
        end
      end

      // The FIFO answers a pop one cycle later, so wait out the cycle in
      // which the pop strobe is still high before capturing the token.
      S_LATCH: begin
        if (!rd_en_reg) begin
          opcode_next = bus.command_in[OPCODE_LSB +: OPCODE_W];
          arg1_next   = bus.command_in[ARG1_LSB +: ARG1_W];
          arg2_next   = bus.command_in[ARG2_LSB +: ARG2_W];
          state_next  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_STP: begin
            if (arg2 > ARG2_W'(MAX_DEGREE)) begin
              go_out   = 1'b1;
              out_code = ST_BAD_ARG;
            end
          end
          OP_EVP: begin
            if (!tbl_rd_valid) begin
              go_out   = 1'b1;
              out_code = ST_UNDEF_VEC;
            end
          end
          OP_EVB: begin
            if (arg2 == '0) begin
              go_out   = 1'b1;
              out_code = ST_BAD_ARG;
            end else if (!tbl_rd_valid) begin
              go_out   = 1'b1;
              out_code = ST_UNDEF_VEC;
            end
          end
          OP_RST: begin
          end
          default: begin
            go_out   = 1'b1;
            out_code = ST_BAD_OP;
          end
        endcase
        if (!go_out) begin
          state_next = S_WAIT_EN;
          mode_next  = opcode_mode(opcode);
          b_next     = arg2;
          vec_next   = arg1;
          n_next     = (opcode == OP_STP) ? arg2[DEGREE_W-1:0] : tbl_rd_degree;
        end
      end

      S_WAIT_EN: begin
        if (bus.enable) begin
          if (opcode == OP_RST) begin
            tbl_clear = 1'b1;
            go_out    = 1'b1;
            out_code  = ST_OK;
          end else begin
            start_next = 1'b1;
            state_next = S_RUN;
`ifdef PEA_DP_TIMEOUT_EN
            timer_next = '0;
`endif
          end
        end
      end

      S_RUN: begin
        if (bus.dp_done) begin
          tbl_wr   = (opcode == OP_STP) && !bus.dp_error;
          go_out   = 1'b1;
          out_code = bus.dp_error ? ST_DP_ERR : ST_OK;
        end
`ifdef PEA_DP_TIMEOUT_EN
        else if (timer == TIMER_W'(timeout_cycles - 1)) begin
          go_out   = 1'b1;
          out_code = ST_TIMEOUT;
        end else begin
          timer_next = timer + 1'b1;
        end
`endif
      end

      S_OUT: begin
        if (bus.enable) begin
          wr_next     = 1'b1;
          status_next = {opcode, code};
          state_next  = S_GET;
          mode_next   = MODE_GET;
        end
      end

      default: begin
        state_next = S_GET;
        mode_next  = MODE_GET;
      end
    endcase

    // Common entry into S_OUT; a successful EVB reports its count on b
    if (go_out) begin
      state_next = S_OUT;
      mode_next  = MODE_OUT;
      code_next  = out_code;
      b_next     = (opcode == OP_EVB && out_code == ST_OK) ? arg2 : ARG2_W'(1);
    end
  end

  assign bus.command_rd_en = rd_en_reg;
  assign bus.mode          = mode_reg;
  assign bus.b             = b_reg;
  assign bus.N             = n_reg;
  assign bus.vec_id        = vec_reg;
  assign bus.dp_start      = start_reg;
  assign bus.status_wr_en  = wr_reg;
  assign bus.status_out    = status_reg;

endmodule

`default_nettype wire

// File: tb/tb_pea_controller.sv
// ============================================================================
//  Module      : tb_pea_controller
//  Description : Self-checking bench for pea_controller with a command FIFO
//                model, a datapath model and a status scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pea_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pea_controller_if bus();

  pea_controller #(
    .buffer_size    (1024),
    .timeout_cycles (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pop_empty = 0;
  int dp_delay = 1;
  bit dp_err = 1'b0;
  int dp_wait = 0;

  logic [15:0] cmd_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_tok;

  int r_lat, r_pops, r_starts, r_mask, r_n;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Command FIFO: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (bus.command_rd_en) begin
      if (cmd_q.size() > 0) bus.command_in <= cmd_q.pop_front();
      else begin
        bus.command_in <= 16'h0000;
        pop_empty++;
      end
    end
  end

  // Datapath: dp_done dp_delay cycles after dp_start (0 = never)
  always @(posedge clk) begin
    bus.dp_done  <= 1'b0;
    bus.dp_error <= 1'b0;
    if (bus.dp_start && dp_delay > 0) begin
      if (dp_delay == 1) begin
        bus.dp_done  <= 1'b1;
        bus.dp_error <= dp_err;
      end else dp_wait <= dp_delay - 1;
    end else if (dp_wait > 0) begin
      if (dp_wait == 1) begin
        bus.dp_done  <= 1'b1;
        bus.dp_error <= dp_err;
      end
      dp_wait <= dp_wait - 1;
    end
  end

  // Scoreboard monitor: every status push must match the queued expectation
  always @(negedge clk) begin
    if (!rst && bus.status_wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL status_unexpected actual=%h required=none", bus.status_out);
      end else begin
        exp_tok = exp_q.pop_front();
        if (bus.status_out !== exp_tok) begin
          bad++;
          $display("FAIL status_token actual=%h required=%h", bus.status_out, exp_tok);
        end
      end
    end
  end

  // Issue one command and follow it to its status push. Called at a negedge.
  task automatic run_cmd(input logic [15:0] cmd, input logic [15:0] exp,
                         input int delay, input bit err,
                         input int hold, input logic [4:0] hold_b);
    int  rd_cyc;
    bit  got;
    bit  held;
    cmd_q.push_back(cmd);
    exp_q.push_back(exp);
    dp_delay = delay;
    dp_err   = err;
    r_lat = -1; r_pops = 0; r_starts = 0; r_mask = 0; r_n = -1;
    rd_cyc = 0; got = 1'b0; held = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r_mask |= (1 << bus.mode);
      if (bus.command_rd_en) begin
        r_pops++;
        rd_cyc = i;
      end
      if (bus.dp_start) begin
        r_starts++;
        r_n = bus.N;
      end
      if (bus.status_wr_en) begin
        r_lat = i - rd_cyc;
        got = 1'b1;
        break;
      end
      if (hold > 0 && !held && bus.mode == 3'd5) begin
        held = 1'b1;
        bus.enable = 1'b0;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          check("hold_b", bus.b, hold_b);
          check("hold_no_status", bus.status_wr_en, 0);
        end
        bus.enable = 1'b1;
      end
    end
    bus.enable = 1'b0;
    if (!got) check("status_timeout", 0, 1);
  endtask

  initial begin
    int found;
    int wr_seen;
    bus.enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_mode", bus.mode, 0);
    check("rst_b", bus.b, 0);
    check("rst_N", bus.N, 0);
    check("rst_vec_id", bus.vec_id, 0);
    check("rst_rd_en", bus.command_rd_en, 0);
    check("rst_dp_start", bus.dp_start, 0);
    check("rst_status_wr_en", bus.status_wr_en, 0);
    check("rst_status_out", bus.status_out, 0);

    // STP vector 1, N=5, datapath done 3 cycles after start
    run_cmd(16'h0125, 16'h0100, 3, 1'b0, 0, 5'd0);
    check("stp_pops", r_pops, 1);
    check("stp_starts", r_starts, 1);
    check("stp_N", r_n, 5);
    check("stp_latency", r_lat, 9);

    // EVP vector 1 at minimum turnaround; N comes from the table
    run_cmd(16'h0220, 16'h0200, 1, 1'b0, 0, 5'd0);
    check("evp_latency", r_lat, 7);
    check("evp_N", r_n, 5);

    // EVB on undefined vector 2
    run_cmd(16'h0342, 16'h0302, 1, 1'b0, 0, 5'd0);
    check("evb_undef_starts", r_starts, 0);
    check("evb_undef_latency", r_lat, 4);

    // Unknown opcode: mode only ever 0 or 5
    run_cmd(16'h0700, 16'h0701, 1, 1'b0, 0, 5'd0);
    check("badop_modes", r_mask, 32'h21);
    check("badop_starts", r_starts, 0);

    // Argument range boundaries
    run_cmd(16'h0130, 16'h0103, 1, 1'b0, 0, 5'd0);
    check("stp16_starts", r_starts, 0);
    run_cmd(16'h012F, 16'h0100, 1, 1'b0, 0, 5'd0);
    check("stp15_N", r_n, 15);
    run_cmd(16'h0320, 16'h0303, 1, 1'b0, 0, 5'd0);

    // Datapath error on STP leaves vector 3 undefined
    run_cmd(16'h0167, 16'h0104, 2, 1'b1, 0, 5'd0);
    check("stp_err_starts", r_starts, 1);
    run_cmd(16'h0260, 16'h0202, 1, 1'b0, 0, 5'd0);

    // EVB vector 1, b=4, enable held low 10 cycles in S_OUT
    run_cmd(16'h0324, 16'h0300, 1, 1'b0, 10, 5'd4);

    // RST clears the table
    run_cmd(16'h0400, 16'h0400, 1, 1'b0, 0, 5'd0);
    check("rst_cmd_starts", r_starts, 0);
    check("rst_cmd_latency", r_lat, 5);
    run_cmd(16'h0220, 16'h0202, 1, 1'b0, 0, 5'd0);

    // Later STP overwrites the entry
    run_cmd(16'h0129, 16'h0100, 1, 1'b0, 0, 5'd0);
    run_cmd(16'h0123, 16'h0100, 1, 1'b0, 0, 5'd0);
    run_cmd(16'h0220, 16'h0200, 1, 1'b0, 0, 5'd0);
    check("overwrite_N", r_n, 3);

    // Reset during S_RUN: no status, late dp_done ignored
    cmd_q.push_back(16'h0145);
    dp_delay = 20;
    dp_err = 1'b0;
    bus.enable = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (bus.dp_start) found = 1;
    end
    check("abort_start_seen", found, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_mode", bus.mode, 0);
    wr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.status_wr_en) wr_seen++;
    end
    check("abort_no_status", wr_seen, 0);
    run_cmd(16'h0240, 16'h0202, 1, 1'b0, 0, 5'd0);

`ifdef PEA_DP_TIMEOUT_EN
    // Watchdog: EVP with no dp_done times out on cycle 16 of S_RUN
    run_cmd(16'h0125, 16'h0100, 1, 1'b0, 0, 5'd0);
    run_cmd(16'h0220, 16'h0205, 0, 1'b0, 0, 5'd0);
    check("timeout_latency", r_lat, 21);
`endif

    repeat (3) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);
    check("empty_pops", pop_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pea_controller.md
# pea_controller

Top-level sequencer for the Polynomial Evaluation Accelerator. It pops 16-bit command tokens, decodes them, and keeps a per-vector degree table. It drives `mode`, `b` and `N` to the enable block and sequences the evaluation datapath through a start/done handshake. After each command it writes exactly one status token. It sits between the command FIFO, the enable block and the datapath.

## Interface
- `buffer_size`, 1024: FIFO depth in words. Count width is `log2(buffer_size)`, using the same log2 function as the rest of the PEA.
- `timeout_cycles`, 4096: watchdog limit on datapath busy time. Used only when the watchdog is compiled in.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `command_in` input 16: command token. Fields are [15:8] opcode, [7:5] arg1 (vector id), [4:0] arg2.
- `command_rd_en` output 1: one-cycle pop strobe. The FIFO presents data on `command_in` the next cycle.
- `enable` input 1: fire permission from the enable block for the current `mode`.
- `mode` output 3: 0 GET_COMMAND, 1 STP, 2 EVP, 3 EVB, 4 RST, 5 OUTPUT.
- `b` output 5: second argument or count presented to the enable block.
- `N` output 4: degree of the addressed vector.
- `vec_id` output 3: addressed coefficient vector.
- `dp_start` output 1: one-cycle pulse that launches the datapath operation selected by `mode`.
- `dp_done` input 1: one-cycle datapath completion pulse.
- `dp_error` input 1: qualifies `dp_done`. 1 means overflow or failure.
- `status_wr_en` output 1: one-cycle status FIFO push.
- `status_out` output 16: [15:8] echoed opcode, [7:0] status code.

## Operation
- Opcodes: 0x01 STP, 0x02 EVP, 0x03 EVB, 0x04 RST. Any other value is BAD_OP.
- Status codes: 0x00 OK, 0x01 BAD_OP, 0x02 UNDEF_VEC, 0x03 BAD_ARG, 0x04 DP_ERR, 0x05 TIMEOUT.
- FSM states: S_GET, S_LATCH, S_DECODE, S_WAIT_EN, S_RUN, S_OUT.
- **S_GET** (mode 0): when `enable`=1, pulse `command_rd_en` and go to S_LATCH.
- **S_LATCH**: register `command_in` into the opcode, arg1 and arg2 registers. Go to S_DECODE.
- **S_DECODE**: check the command. Any error jumps straight to S_OUT with that error code.
  - BAD_OP: unknown opcode.
  - BAD_ARG: STP with arg2 > 15, or EVB with arg2 = 0.
  - UNDEF_VEC: EVP or EVB naming a vector whose table entry is invalid.
  - Otherwise go to S_WAIT_EN with `mode` set to the opcode's mode.
- **S_WAIT_EN**: drive `b`=arg2, `vec_id`=arg1, `N`=table degree. For STP, `N`=arg2. When `enable`=1:
  - RST: clear all table valid bits, code OK, go to S_OUT. No `dp_start` is issued.
  - Other commands: pulse `dp_start` and go to S_RUN.
- **S_RUN**: hold `mode`. On `dp_done`:
  - STP: write table[arg1] = {valid=1, degree=arg2}, but only if `dp_error`=0.
  - Code is DP_ERR if `dp_error` was set, else OK. Go to S_OUT.
- **S_OUT** (mode 5): drive `b` = arg2 for a successful EVB, else `b` = 1. When `enable`=1, pulse `status_wr_en` with the code and go to S_GET.
- Degree table: 8 entries of {valid, 4-bit degree}. A later STP to the same id overwrites the entry.

## Timing
- Reset values:
  - State S_GET.
  - `mode`=0, `b`=0, `N`=0, `vec_id`=0.
  - `command_rd_en`=0, `dp_start`=0, `status_wr_en`=0, `status_out`=0.
  - All table valid bits cleared.
- All outputs are registered.
- `rst` mid-operation aborts immediately. No status is written for the aborted command, and a `dp_done` arriving after reset is ignored.
- Minimum command turnaround, with `enable` high throughout and `dp_done` one cycle after `dp_start`: 7 cycles from `command_rd_en` to `status_wr_en`.
- An error path skips S_WAIT_EN and S_RUN: 3 cycles from `command_rd_en` to reaching S_OUT.
- `dp_done` outside S_RUN is ignored.
- `enable` is sampled only in S_GET, S_WAIT_EN and S_OUT.

## Configuration
- Macro: `PEA_DP_TIMEOUT_EN`.
- Defined: a counter cleared on `dp_start` counts cycles in S_RUN. On reaching `timeout_cycles` without `dp_done`, the FSM goes to S_OUT with code TIMEOUT. STP does not update the table in that case.
- Undefined: no counter. S_RUN waits indefinitely.

## Structure
- Package `pea_pkg` holds:
  - mode encodings, opcodes and status codes;
  - token field positions and widths;
  - the shared log2 function.
- Sub-module `pea_degree_table`: 8×5 register file with synchronous write, clear-all and combinational read.

## Test plan
- Reset, then STP 0x0125 (vector 1, N=5) with `enable`=1 and `dp_done` after 3 cycles → table[1] = {1,5}; status 0x0100; exactly one `command_rd_en`.
- EVB 0x0342 (vector 2, b=2) with vector 2 undefined → no `dp_start`; status 0x0302.
- Opcode 0x07 → status 0x0701; `mode` never leaves 0 or 5.
- STP to vector 1, then RST 0x0400, then EVP 0x0220 (vector 1) → status 0x0400, then 0x0202.
- EVB vector 1, b=4 with `enable` held 0 for 10 cycles in S_OUT → `b`=4 held; `status_wr_en` only after `enable` rises.
- With `PEA_DP_TIMEOUT_EN` defined and `timeout_cycles`=16, EVP with `dp_done` never asserted → status 0x0205 at cycle 16 of S_RUN.
